// File: rtl/uart_tx.sv
// uart_tx: 8N1 / 8E1 / 8O1 serial transmitter.
// A frame is accepted from IDLE when tx_en and txStart are both high. The
// byte is latched, then start, 8 data bits LSB first, an optional parity bit
// and one stop bit are shifted out, each bit lasting CLKS_PER_BIT cycles.
// All outputs are registered; tx is computed from the next-state values so
// the line changes in the same cycle the state does.
//
// state  | meaning
// -------+--------------------------------------------
// IDLE   | line high, waiting for an accepted request
// START  | start bit (tx=0)
// DATA   | data bits 0..7, LSB first
// PARITY | parity bit (only when PARITY_EN=1)
// STOP   | stop bit (tx=1); txDone pulses on exit

module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       txStart,
    input  logic [7:0] txData,
    output logic       tx,
    output logic       txDone,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic PAR_INV = (PARITY_ODD != 0);
    localparam logic PAR_ON  = (PARITY_EN != 0);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    // Next-state, counters and the registered output values.
    always_comb begin
        state_d   = state_q;
        baud_d    = bit_end ? '0 : baud_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_d    = '0;
                bit_idx_d = 3'd0;
                // The txDone cycle never accepts, guaranteeing an idle gap.
                if (!done_q && tx_en && txStart) begin
                    state_d = ST_START;
                    shift_d = txData;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = PAR_ON ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
            end
        endcase

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[bit_idx_d];
            ST_PARITY: tx_d = (^shift_d) ^ PAR_INV;
            default:   tx_d = 1'b1;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any frame without txDone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign tx     = tx_q;
    assign txDone = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx with CLKS_PER_BIT=4 on three
// instances (no parity, even parity, odd parity) sharing the same inputs.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic       txStart = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       tx_o   [3];
    logic       done_o [3];
    logic       busy_o [3];

    int vectors = 0;
    int miscompares = 0;
    int k = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .txStart(txStart), .txData(txData),
        .tx(tx_o[0]), .txDone(done_o[0]), .busy(busy_o[0]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .txStart(txStart), .txData(txData),
        .tx(tx_o[1]), .txDone(done_o[1]), .busy(busy_o[1]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .txStart(txStart), .txData(txData),
        .tx(tx_o[2]), .txDone(done_o[2]), .busy(busy_o[2]));

    // Expected {tx, busy, txDone} k cycles after the acceptance cycle.
    function automatic logic [2:0] model(input logic [7:0] d, input int pen,
                                         input int podd, input int kk);
        int frame_len, last, b;
        logic t;
        frame_len = 10 + pen;
        last = frame_len * 4;
        if (kk >= 1 && kk <= last) begin
            b = (kk - 1) / 4;
            if (b == 0)                  t = 1'b0;
            else if (b <= 8)             t = d[b-1];
            else if (pen == 1 && b == 9) t = (^d) ^ podd[0];
            else                         t = 1'b1;
            return {t, 1'b1, 1'b0};
        end
        return {1'b1, 1'b0, (kk == last + 1)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s k=%0d got %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic chk_exp(input int i, input string name, input logic [2:0] m);
        chk($sformatf("%s.u%0d.tx", name, i),     tx_o[i],   m[2]);
        chk($sformatf("%s.u%0d.busy", name, i),   busy_o[i], m[1]);
        chk($sformatf("%s.u%0d.txDone", name, i), done_o[i], m[0]);
    endtask

    task automatic chk_dut(input int i, input string name, input logic [7:0] d);
        chk_exp(i, name, model(d, (i > 0) ? 1 : 0, (i == 2) ? 1 : 0, k));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Accept one frame of d on all three instances, then check every cycle up
    // to kmax. mode 1: re-request with FF at N+10; mode 2: tx_en drops at N+5
    // with txStart held from N+30; mode 3: reset at N+20.
    task automatic frame_test(input string name, input logic [7:0] d,
                              input int kmax, input int mode);
        do_reset();
        tx_en = 1'b1;
        txData = d;
        txStart = 1'b1;
        tick();
        k = 1;
        txStart = 1'b0;
        while (k <= kmax) begin
            for (int i = 0; i < 3; i++) begin
                if (mode == 3 && k > 20) chk_exp(i, name, 3'b100);
                else                     chk_dut(i, name, d);
            end
            if (mode == 1 && k == 10) begin txData = 8'hFF; txStart = 1'b1; end
            if (mode == 1 && k == 11) txStart = 1'b0;
            if (mode == 2 && k == 5)  tx_en = 1'b0;
            if (mode == 2 && k == 30) txStart = 1'b1;
            if (mode == 3 && k == 20) rst = 1'b1;
            if (mode == 3 && k == 21) rst = 1'b0;
            tick();
            k++;
        end
        txStart = 1'b0;
        tx_en = 1'b1;
    endtask

    initial begin
        // Reset state.
        tick();
        tick();
        k = 0;
        for (int i = 0; i < 3; i++) chk_exp(i, "reset", 3'b100);
        rst = 1'b0;

        // Basic A5 frame (parity instances: even 0, odd 1).
        frame_test("basic_a5", 8'hA5, 46, 0);
        // Parity on 07 (even 1, odd 0), txDone at N+45 on parity instances.
        frame_test("parity_07", 8'h07, 47, 0);
        // Re-request while busy is ignored.
        frame_test("ignore_busy", 8'hA5, 48, 1);
        // tx_en dropped mid-frame: frame completes, no further acceptance.
        frame_test("en_drop", 8'hA5, 55, 2);
        // Reset mid-frame aborts with no txDone.
        frame_test("rst_mid", 8'hA5, 50, 3);

        // Back-to-back with txStart held: 55 then AA on the no-parity instance.
        do_reset();
        tx_en = 1'b1;
        txData = 8'h55;
        txStart = 1'b1;
        tick();
        k = 1;
        while (k <= 86) begin
            if (k <= 42) chk_exp(0, "b2b", model(8'h55, 0, 0, k));
            else         chk_exp(0, "b2b", model(8'hAA, 0, 0, k - 42));
            if (k == 1)  txData = 8'hAA;
            if (k == 83) txStart = 1'b0;
            tick();
            k++;
        end

        // Gating: tx_en=0 with txStart high for 50 cycles.
        do_reset();
        tx_en = 1'b0;
        txData = 8'h5A;
        txStart = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            k = 100 + c;
            for (int i = 0; i < 3; i++) chk_exp(i, "gated", 3'b100);
        end
        txStart = 1'b0;

        // Acceptance in the first cycle after reset releases.
        rst = 1'b1;
        tx_en = 1'b1;
        txData = 8'h3C;
        txStart = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        k = 1;
        txStart = 1'b0;
        while (k <= 8) begin
            chk_dut(0, "post_rst", 8'h3C);
            tick();
            k++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
